port_cycle_controller: RTL and testbench

- Parametrised 68030 port cycle controller for one decoded peripheral/memory port of 8, 16 or 32 bits.
- Generates per-byte-lane write selects from A1:A0/SIZ1:SIZ0.
- Inserts programmable wait states plus device-extended waits, then drives DSACK1/DSACK0 encoded for the port width.
- Asserts BERR on timeout. One instance sits between the address decoder and each port.

---
 rtl/port_cycle_controller.sv | 123 ++++++++++++
 tb/tb_port_cycle_controller.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/port_cycle_controller.sv
// 68030 bus-cycle controller for one decoded 8/16/32-bit port: byte-lane selects,
// programmable and device-extended wait states, DSACK encoding and bus-error timeout.
module port_cycle_controller #(
  parameter int PORT_WIDTH  = 32,
  parameter int WAIT_STATES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       cs,
  input  logic       n_as,
  input  logic       rn_w,
  input  logic       a0,
  input  logic       a1,
  input  logic       siz0,
  input  logic       siz1,
  input  logic       dev_ready,
  output logic [3:0] lane_sel,
  output logic       n_dsack0,
  output logic       n_dsack1,
  output logic       n_berr,
  output logic       busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] ACK    = 2'd2;
  localparam logic [1:0] S_BERR = 2'd3;

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  localparam logic [3:0] PORT_MASK = (PORT_WIDTH == 32) ? 4'b1111 :
                                     (PORT_WIDTH == 16) ? 4'b1100 : 4'b1000;

  logic [1:0]    state_reg, state_next;
  logic [3:0]    wait_reg, wait_next;
  logic [TW-1:0] to_reg, to_next;
  logic [2:0]    offset, byte_cnt, upper;
  logic [3:0]    write_hit, lanes_new;

  // Lane k (k=0 is the most significant byte) is written iff offset <= k < offset+count.
  always_comb begin
    byte_cnt = ({siz1, siz0} == 2'b00) ? 3'd4 : {1'b0, siz1, siz0};
    offset   = (PORT_WIDTH == 16) ? {2'b00, a0} : {1'b0, a1, a0};
    upper    = offset + byte_cnt;
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign write_hit[3-gi] = (3'(gi) >= offset) && (3'(gi) < upper);
    end
  endgenerate

  always_comb begin
    if (rn_w)
      lanes_new = PORT_MASK;
    else if (PORT_WIDTH == 8)
      lanes_new = 4'b1000;
    else
      lanes_new = write_hit & PORT_MASK;
  end

  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    to_next    = to_reg;
    case (state_reg)
      IDLE: begin
        if (cs && !n_as) begin
          state_next = WAIT;
          wait_next  = WS;
          to_next    = '0;
        end
      end
      WAIT: begin
        // Priority: abort, then acknowledge, then timeout.
        if (n_as)
          state_next = IDLE;
        else if (wait_reg == 4'd0 && dev_ready)
          state_next = ACK;
        else if ((TIMEOUT != 0) && (to_reg == TO_LAST))
          state_next = S_BERR;
        else begin
          if (wait_reg != 4'd0)
            wait_next = wait_reg - 4'd1;
          to_next = to_reg + TW'(1);
        end
      end
      default: begin
        if (n_as)
          state_next = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_reg <= IDLE;
      wait_reg  <= 4'd0;
      to_reg    <= '0;
      lane_sel  <= 4'b0000;
      n_dsack0  <= 1'b1;
      n_dsack1  <= 1'b1;
      n_berr    <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      to_reg    <= to_next;
      if (state_next == IDLE)
        lane_sel <= 4'b0000;
      else if (state_reg == IDLE)
        lane_sel <= lanes_new;
      n_dsack1 <= !((state_next == ACK) && (PORT_WIDTH != 8));
      n_dsack0 <= !((state_next == ACK) && (PORT_WIDTH != 16));
      n_berr   <= (state_next != S_BERR);
      busy     <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_port_cycle_controller.sv
// Directed bench for port_cycle_controller: five instances with different widths,
// wait states and timeouts share the CPU bus; each has its own chip select.
module tb_port_cycle_controller;

  logic       clk = 1'b0;
  logic       n_reset, n_as, rn_w, a0, a1, siz0, siz1, dev_ready;
  logic [4:0] cs;
  logic [3:0] lane [5];
  logic       ds0 [5];
  logic       ds1 [5];
  logic       berr [5];
  logic       bsy [5];
  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  // 0: 32-bit WS=2, 1: 16-bit WS=0, 2: 8-bit WS=0, 3: 32-bit WS=1 TO=8, 4: 32-bit WS=4
  port_cycle_controller #(.PORT_WIDTH(32), .WAIT_STATES(2), .TIMEOUT(64)) u32 (
    .clk(clk), .n_reset(n_reset), .cs(cs[0]), .n_as(n_as), .rn_w(rn_w), .a0(a0), .a1(a1),
    .siz0(siz0), .siz1(siz1), .dev_ready(dev_ready), .lane_sel(lane[0]),
    .n_dsack0(ds0[0]), .n_dsack1(ds1[0]), .n_berr(berr[0]), .busy(bsy[0]));
  port_cycle_controller #(.PORT_WIDTH(16), .WAIT_STATES(0), .TIMEOUT(64)) u16 (
    .clk(clk), .n_reset(n_reset), .cs(cs[1]), .n_as(n_as), .rn_w(rn_w), .a0(a0), .a1(a1),
    .siz0(siz0), .siz1(siz1), .dev_ready(dev_ready), .lane_sel(lane[1]),
    .n_dsack0(ds0[1]), .n_dsack1(ds1[1]), .n_berr(berr[1]), .busy(bsy[1]));
  port_cycle_controller #(.PORT_WIDTH(8), .WAIT_STATES(0), .TIMEOUT(64)) u8 (
    .clk(clk), .n_reset(n_reset), .cs(cs[2]), .n_as(n_as), .rn_w(rn_w), .a0(a0), .a1(a1),
    .siz0(siz0), .siz1(siz1), .dev_ready(dev_ready), .lane_sel(lane[2]),
    .n_dsack0(ds0[2]), .n_dsack1(ds1[2]), .n_berr(berr[2]), .busy(bsy[2]));
  port_cycle_controller #(.PORT_WIDTH(32), .WAIT_STATES(1), .TIMEOUT(8)) u_to (
    .clk(clk), .n_reset(n_reset), .cs(cs[3]), .n_as(n_as), .rn_w(rn_w), .a0(a0), .a1(a1),
    .siz0(siz0), .siz1(siz1), .dev_ready(dev_ready), .lane_sel(lane[3]),
    .n_dsack0(ds0[3]), .n_dsack1(ds1[3]), .n_berr(berr[3]), .busy(bsy[3]));
  port_cycle_controller #(.PORT_WIDTH(32), .WAIT_STATES(4), .TIMEOUT(64)) u_ab (
    .clk(clk), .n_reset(n_reset), .cs(cs[4]), .n_as(n_as), .rn_w(rn_w), .a0(a0), .a1(a1),
    .siz0(siz0), .siz1(siz1), .dev_ready(dev_ready), .lane_sel(lane[4]),
    .n_dsack0(ds0[4]), .n_dsack1(ds1[4]), .n_berr(berr[4]), .busy(bsy[4]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a cycle and advances to edge N (the edge that leaves IDLE).
  task automatic start(input int idx, input logic rnw, input logic [1:0] addr, input logic [1:0] siz);
    cs      = 5'b0;
    cs[idx] = 1'b1;
    rn_w    = rnw;
    {a1, a0}     = addr;
    {siz1, siz0} = siz;
    n_as    = 1'b0;
    tick();
  endtask

  // Negates the strobe, returns to IDLE, then spends one more idle edge.
  task automatic finish();
    n_as = 1'b1;
    cs   = 5'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    n_reset = 1'b0; n_as = 1'b1; cs = 5'b0; rn_w = 1'b1;
    a0 = 1'b0; a1 = 1'b0; siz0 = 1'b0; siz1 = 1'b0; dev_ready = 1'b1;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({lane[i], ds1[i], ds0[i], berr[i], bsy[i]} !== 8'b0000_1110) begin
        fails++;
        $display("FAIL reset inst%0d: got lane=%b ds1=%b ds0=%b berr=%b busy=%b, expected 0000 1 1 1 0",
                 i, lane[i], ds1[i], ds0[i], berr[i], bsy[i]);
      end
    end
    n_reset = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_write_byte32();
    start(0, 1'b0, 2'b01, 2'b01);
    checks++;
    if ({lane[0], ds1[0], ds0[0], bsy[0]} !== 7'b0100_111) begin
      fails++;
      $display("FAIL wr32_edgeN: got lane=%b ds1=%b ds0=%b busy=%b, expected 0100 1 1 1", lane[0], ds1[0], ds0[0], bsy[0]);
    end
    tick(); tick();
    checks++;
    if ({ds1[0], ds0[0]} !== 2'b11) begin
      fails++;
      $display("FAIL wr32_N+2: got dsack=%b%b expected 11", ds1[0], ds0[0]);
    end
    tick();
    checks++;
    if ({lane[0], ds1[0], ds0[0], berr[0]} !== 7'b0100_001) begin
      fails++;
      $display("FAIL wr32_N+3: got lane=%b ds1=%b ds0=%b berr=%b, expected 0100 0 0 1", lane[0], ds1[0], ds0[0], berr[0]);
    end
    n_as = 1'b1; cs = 5'b0;
    tick();
    checks++;
    if ({lane[0], ds1[0], ds0[0], berr[0], bsy[0]} !== 8'b0000_1110) begin
      fails++;
      $display("FAIL wr32_release: got lane=%b ds1=%b ds0=%b berr=%b busy=%b, expected 0000 1 1 1 0",
               lane[0], ds1[0], ds0[0], berr[0], bsy[0]);
    end
    tick();
    $display("test_write_byte32 done");
  endtask

  task automatic test_lanes32();
    logic [1:0] addr_t [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    logic [1:0] siz_t  [4] = '{2'b11, 2'b00, 2'b10, 2'b10};
    logic       rnw_t  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] exp_t  [4] = '{4'b0111, 4'b0011, 4'b1111, 4'b1100};
    for (int i = 0; i < 4; i++) begin
      start(0, rnw_t[i], addr_t[i], siz_t[i]);
      checks++;
      if (lane[0] !== exp_t[i]) begin
        fails++;
        $display("FAIL lanes32_%0d: got lane=%b expected %b", i, lane[0], exp_t[i]);
      end
      finish();
      $display("lanes32 vector %0d done", i);
    end
  endtask

  task automatic test_port16_8();
    start(1, 1'b0, 2'b01, 2'b10);
    checks++;
    if ({lane[1], ds1[1], ds0[1]} !== 6'b0100_11) begin
      fails++;
      $display("FAIL p16_edgeN: got lane=%b ds1=%b ds0=%b, expected 0100 1 1", lane[1], ds1[1], ds0[1]);
    end
    tick();
    checks++;
    if ({lane[1], ds1[1], ds0[1]} !== 6'b0100_01) begin
      fails++;
      $display("FAIL p16_ack: got lane=%b ds1=%b ds0=%b, expected 0100 0 1", lane[1], ds1[1], ds0[1]);
    end
    finish();
    start(2, 1'b1, 2'b11, 2'b01);
    tick();
    checks++;
    if ({lane[2], ds1[2], ds0[2]} !== 6'b1000_10) begin
      fails++;
      $display("FAIL p8_ack: got lane=%b ds1=%b ds0=%b, expected 1000 1 0", lane[2], ds1[2], ds0[2]);
    end
    finish();
    $display("test_port16_8 done");
  endtask

  task automatic test_timeout();
    dev_ready = 1'b0;
    start(3, 1'b1, 2'b00, 2'b00);
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++;
      if ({berr[3], ds1[3], ds0[3]} !== 3'b111) begin
        fails++;
        $display("FAIL to_wait_N+%0d: got berr=%b ds=%b%b expected 1 11", k, berr[3], ds1[3], ds0[3]);
      end
    end
    tick();
    checks++;
    if ({berr[3], ds1[3], ds0[3], bsy[3]} !== 4'b0111) begin
      fails++;
      $display("FAIL to_berr_N+8: got berr=%b ds=%b%b busy=%b expected 0 11 1", berr[3], ds1[3], ds0[3], bsy[3]);
    end
    tick();
    checks++;
    if (berr[3] !== 1'b0) begin
      fails++;
      $display("FAIL to_berr_hold: got berr=%b expected 0", berr[3]);
    end
    n_as = 1'b1; cs = 5'b0;
    tick();
    checks++;
    if ({berr[3], bsy[3], lane[3]} !== 6'b10_0000) begin
      fails++;
      $display("FAIL to_release: got berr=%b busy=%b lane=%b expected 1 0 0000", berr[3], bsy[3], lane[3]);
    end
    tick();
    start(3, 1'b1, 2'b00, 2'b00);
    for (int k = 1; k <= 7; k++) tick();
    dev_ready = 1'b1;
    tick();
    checks++;
    if ({berr[3], ds1[3], ds0[3]} !== 3'b100) begin
      fails++;
      $display("FAIL to_ack_wins: got berr=%b ds=%b%b expected 1 00", berr[3], ds1[3], ds0[3]);
    end
    finish();
    $display("test_timeout done");
  endtask

  task automatic test_abort();
    int seen = 0;
    start(4, 1'b0, 2'b00, 2'b00);
    n_as = 1'b1; cs = 5'b0;
    tick();
    checks++;
    if ({bsy[4], lane[4]} !== 5'b0_0000) begin
      fails++;
      $display("FAIL abort_N+1: got busy=%b lane=%b expected 0 0000", bsy[4], lane[4]);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      if (ds1[4] === 1'b0 || ds0[4] === 1'b0 || berr[4] === 1'b0 || bsy[4] !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL abort_quiet: got %0d active samples expected 0", seen);
    end
    $display("test_abort done");
  endtask

  task automatic test_back_to_back();
    dev_ready = 1'b0;
    start(0, 1'b1, 2'b00, 2'b00);
    tick(); tick(); tick();
    checks++;
    if ({ds1[0], ds0[0]} !== 2'b11) begin
      fails++;
      $display("FAIL ext_N+3: got dsack=%b%b expected 11", ds1[0], ds0[0]);
    end
    dev_ready = 1'b1;
    tick();
    checks++;
    if ({ds1[0], ds0[0]} !== 2'b00) begin
      fails++;
      $display("FAIL ext_N+4: got dsack=%b%b expected 00", ds1[0], ds0[0]);
    end
    n_as = 1'b1;
    tick();
    n_as = 1'b0; rn_w = 1'b0; {a1, a0} = 2'b11; {siz1, siz0} = 2'b01;
    tick();
    checks++;
    if ({lane[0], bsy[0]} !== 5'b0001_1) begin
      fails++;
      $display("FAIL b2b_second: got lane=%b busy=%b expected 0001 1", lane[0], bsy[0]);
    end
    finish();
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_in_ack();
    start(0, 1'b1, 2'b00, 2'b00);
    tick(); tick(); tick();
    checks++;
    if ({ds1[0], ds0[0]} !== 2'b00) begin
      fails++;
      $display("FAIL rst_pre_ack: got dsack=%b%b expected 00", ds1[0], ds0[0]);
    end
    #2 n_reset = 1'b0;
    #1;
    checks++;
    if ({lane[0], ds1[0], ds0[0], berr[0], bsy[0]} !== 8'b0000_1110) begin
      fails++;
      $display("FAIL rst_async: got lane=%b ds1=%b ds0=%b berr=%b busy=%b, expected 0000 1 1 1 0",
               lane[0], ds1[0], ds0[0], berr[0], bsy[0]);
    end
    n_as = 1'b1;
    tick();
    n_reset = 1'b1;
    tick(); tick();
    checks++;
    if ({bsy[0], ds1[0], ds0[0]} !== 3'b011) begin
      fails++;
      $display("FAIL rst_stay_idle: got busy=%b dsack=%b%b expected 0 11", bsy[0], ds1[0], ds0[0]);
    end
    cs = 5'b0;
    $display("test_reset_in_ack done");
  endtask

  initial begin
    test_reset();
    test_write_byte32();
    test_lanes32();
    test_port16_8();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_reset_in_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
